// File: rtl/stack_pkg.sv
// Shared definitions for the stack datapath: default sizes, stack
// operation codes and ALU function codes.
package stack_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [2:0] {
    SOP_NOP      = 3'd0,
    SOP_PUSH     = 3'd1,
    SOP_REPLACE2 = 3'd2,
    SOP_DROP     = 3'd3,
    SOP_TEST     = 3'd4,
    SOP_SWAP     = 3'd5
  } stack_op_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_DUP  = 4'd5,
    ALU_OVER = 4'd6,
    ALU_EQ   = 4'd7,
    ALU_ZERO = 4'd8,
    ALU_SLT  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for the stack datapath. Operand a is the top of
// stack, b the second entry; binary ops are written b <op> a so that
// the operand pushed first is the left-hand side.
module stack_alu
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluOP,
  output logic [WIDTH-1:0] result,
  output logic             Overflow
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  alu_op_e          op;

  assign sum  = b + a;
  assign diff = b - a;
  assign op   = alu_op_e'(aluOP);

  // Function select; overflow is only meaningful for ADD and SUB.
  always_comb begin
    result   = '0;
    Overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum;
        Overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        Overflow = (b[WIDTH-1] != a[WIDTH-1]) && (diff[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_AND:  result = b & a;
      ALU_OR:   result = b | a;
      ALU_XOR:  result = b ^ a;
      ALU_DUP:  result = a;
      ALU_OVER: result = b;
      ALU_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
      ALU_ZERO: result = {{(WIDTH-1){1'b0}}, (a == '0)};
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(b) < $signed(a))};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/integration_push_pop_unit.sv
// Stack processor datapath: register-file stack plus combinational ALU.
// One stack operation is applied per rising CLK edge; reset is
// asynchronous and active-low and clears the whole stack.
// Optional build macro STACK_STATUS_EN adds an occupancy counter with
// empty/full outputs; data movement is the same either way.
module integration_push_pop_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [2:0]       stackOP,
  input  logic [3:0]       aluOP,
  input  logic [WIDTH-1:0] immediate,
  input  logic             mux_selector,
  output logic             Overflow,
  output logic [WIDTH-1:0] aOut,
  output logic [WIDTH-1:0] bOut,
  output logic [WIDTH-1:0] ALU_out
`ifdef STACK_STATUS_EN
  ,
  output logic             empty,
  output logic             full
`endif
);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] push_data;
  stack_op_e        op;

  assign op = stack_op_e'(stackOP);

  stack_alu #(.WIDTH(WIDTH)) u_alu (
    .a        (stack_q[0]),
    .b        (stack_q[1]),
    .aluOP    (aluOP),
    .result   (alu_result),
    .Overflow (Overflow)
  );

  assign ALU_out   = alu_result;
  assign aOut      = stack_q[0];
  assign bOut      = stack_q[1];
  assign push_data = mux_selector ? immediate : alu_result;

  // Next stack contents for the requested operation; TEST/NOP hold.
  always_comb begin
    stack_d = stack_q;
    case (op)
      SOP_PUSH: begin
        stack_d[0] = push_data;
        for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
      end
      SOP_REPLACE2: begin
        // Both operands and the entry under them are consumed; the
        // result lands on top and the rest moves up by two.
        stack_d[0] = alu_result;
        for (int i = 1; i < DEPTH - 2; i++) stack_d[i] = stack_q[i+2];
        stack_d[DEPTH-2] = '0;
        stack_d[DEPTH-1] = '0;
      end
      SOP_DROP: begin
        for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
        stack_d[DEPTH-1] = '0;
      end
      SOP_SWAP: begin
        stack_d[0] = stack_q[1];
        stack_d[1] = stack_q[0];
      end
      default: stack_d = stack_q;
    endcase
  end

  // Stack register array with asynchronous clear.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      stack_q <= stack_d;
    end
  end

`ifdef STACK_STATUS_EN
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Occupancy tracking: saturates at DEPTH, floors at zero.
  always_comb begin
    count_d = count_q;
    case (op)
      SOP_PUSH: begin
        if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
      end
      SOP_DROP, SOP_REPLACE2: begin
        if (count_q != '0) count_d = count_q - CNT_W'(1);
      end
      default: count_d = count_q;
    endcase
  end

  // Occupancy counter register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_integration_push_pop_unit.sv
// Self-checking bench for integration_push_pop_unit: directed cases
// followed by randomized operations, compared to a queue-based model.
module tb_integration_push_pop_unit;

  localparam int W = 16;
  localparam int D = 16;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_REP2 = 3'd2;
  localparam logic [2:0] OP_DROP = 3'd3;
  localparam logic [2:0] OP_TEST = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;

  logic         CLK = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   stackOP = '0;
  logic [3:0]   aluOP = '0;
  logic [W-1:0] immediate = '0;
  logic         mux_selector = 1'b1;
  logic         Overflow;
  logic [W-1:0] aOut, bOut, ALU_out;
`ifdef STACK_STATUS_EN
  logic         empty, full;
`endif

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mq[$];
  int           mcount;
  logic [W-1:0] last_alu;
  logic         last_ovf;

  integration_push_pop_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .stackOP      (stackOP),
    .aluOP        (aluOP),
    .immediate    (immediate),
    .mux_selector (mux_selector),
    .Overflow     (Overflow),
    .aOut         (aOut),
    .bOut         (bOut),
    .ALU_out      (ALU_out)
`ifdef STACK_STATUS_EN
    ,
    .empty        (empty),
    .full         (full)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ALU reference computed on signed integers.
  function automatic void model_alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic ov);
    int sa, sb, t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ov = 1'b0;
    r  = '0;
    case (op)
      0: begin t = sb + sa; r = W'(t); ov = (t > 32767) || (t < -32768); end
      1: begin t = sb - sa; r = W'(t); ov = (t > 32767) || (t < -32768); end
      2: r = b & a;
      3: r = b | a;
      4: r = b ^ a;
      5: r = a;
      6: r = b;
      7: r = (a == b) ? 16'd1 : 16'd0;
      8: r = (a == 0) ? 16'd1 : 16'd0;
      9: r = (sb < sa) ? 16'd1 : 16'd0;
      default: r = '0;
    endcase
  endfunction

  function automatic void model_clear();
    mq.delete();
    for (int i = 0; i < D; i++) mq.push_back('0);
    mcount = 0;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_aOut"}, 32'(aOut), 32'(mq[0]));
    chk({tag, "_bOut"}, 32'(bOut), 32'(mq[1]));
`ifdef STACK_STATUS_EN
    chk({tag, "_empty"}, 32'(empty), 32'(mcount == 0));
    chk({tag, "_full"}, 32'(full), 32'(mcount == D));
`endif
  endtask

  // Apply one operation: check combinational outputs before the edge,
  // registered outputs after it.
  task automatic step(input logic [2:0] op, input logic [3:0] alu, input logic [W-1:0] imm,
                      input logic mux);
    logic [W-1:0] er;
    logic         eo;
    logic [W-1:0] data;
    stackOP = op; aluOP = alu; immediate = imm; mux_selector = mux;
    #1;
    model_alu(int'(alu), mq[0], mq[1], er, eo);
    chk("alu_out", 32'(ALU_out), 32'(er));
    chk("overflow", 32'(Overflow), 32'(eo));
    last_alu = ALU_out;
    last_ovf = Overflow;
    case (op)
      OP_PUSH: begin
        data = mux ? imm : er;
        mq.push_front(data);
        void'(mq.pop_back());
        if (mcount < D) mcount++;
      end
      OP_REP2: begin
        void'(mq.pop_front()); void'(mq.pop_front()); void'(mq.pop_front());
        mq.push_front(er);
        mq.push_back('0); mq.push_back('0);
        if (mcount > 0) mcount--;
      end
      OP_DROP: begin
        void'(mq.pop_front());
        mq.push_back('0);
        if (mcount > 0) mcount--;
      end
      OP_SWAP: begin
        data = mq[0]; mq[0] = mq[1]; mq[1] = data;
      end
      default: ;
    endcase
    @(posedge CLK);
    #1;
    check_regs("step");
    stackOP = OP_NOP;
  endtask

  task automatic push(input logic [W-1:0] v);
    step(OP_PUSH, 4'd0, v, 1'b1);
  endtask

  // Asynchronous reset, held across one edge with a PUSH pending.
  task automatic do_reset();
    stackOP = OP_PUSH;
    immediate = 16'h1234;
    mux_selector = 1'b1;
    reset = 1'b0;
    #1;
    model_clear();
    check_regs("rst_async");
    @(posedge CLK);
    #1;
    check_regs("rst_hold");
    reset = 1'b1;
    stackOP = OP_NOP;
  endtask

  initial begin
    model_clear();
    #1;
    check_regs("rst_init");
    aluOP = 4'd0; #1;
    chk("rst_alu_add", 32'(ALU_out), 32'd0);
    aluOP = 4'd8; #1;
    chk("rst_alu_zero", 32'(ALU_out), 32'd1);
    @(posedge CLK); #1;
    reset = 1'b1;

    push(16'd1); push(16'd2); step(OP_REP2, 4'd0, 16'd0, 1'b0);
    chk("rep2_add_a", 32'(aOut), 32'd3);
    chk("rep2_add_b", 32'(bOut), 32'd0);

    do_reset();
    push(16'd1); push(16'd2); step(OP_REP2, 4'd1, 16'd0, 1'b0);
    chk("rep2_sub_a", 32'(aOut), 32'h0000FFFF);

    do_reset();
    push(16'd1); push(16'd3); step(OP_REP2, 4'd3, 16'd0, 1'b0);
    chk("rep2_or_a", 32'(aOut), 32'd3);

    push(16'd1); push(16'd1); step(OP_TEST, 4'd7, 16'd0, 1'b0);
    chk("test_eq_1", 32'(last_alu), 32'd1);
    push(16'd2); push(16'd1); step(OP_TEST, 4'd7, 16'd0, 1'b0);
    chk("test_eq_0", 32'(last_alu), 32'd0);
    push(16'd7); push(16'd0); step(OP_TEST, 4'd8, 16'd0, 1'b0);
    chk("test_zero_1", 32'(last_alu), 32'd1);
    push(16'd7); push(16'd1); step(OP_TEST, 4'd8, 16'd0, 1'b0);
    chk("test_zero_0", 32'(last_alu), 32'd0);

    push(16'd3); step(OP_PUSH, 4'd5, 16'hDEAD, 1'b0);
    chk("dup_a", 32'(aOut), 32'd3);
    chk("dup_b", 32'(bOut), 32'd3);
    push(16'd3); push(16'd7); step(OP_PUSH, 4'd6, 16'hBEEF, 1'b0);
    chk("over_a", 32'(aOut), 32'd3);
    chk("over_b", 32'(bOut), 32'd7);

    do_reset();
    push(16'd3); push(16'd4); push(16'd5); step(OP_DROP, 4'd0, 16'd0, 1'b0);
    chk("drop_a", 32'(aOut), 32'd4);
    chk("drop_b", 32'(bOut), 32'd3);
    step(OP_DROP, 4'd0, 16'd0, 1'b0); step(OP_DROP, 4'd0, 16'd0, 1'b0);
    chk("drop3_a", 32'(aOut), 32'd0);
    chk("drop3_b", 32'(bOut), 32'd0);
    step(OP_DROP, 4'd0, 16'd0, 1'b0);
    chk("drop_empty_a", 32'(aOut), 32'd0);

    push(16'd1); push(16'd2); step(OP_REP2, 4'd9, 16'd0, 1'b0);
    chk("slt_1", 32'(aOut), 32'd1);
    push(16'd2); push(16'd2); step(OP_REP2, 4'd9, 16'd0, 1'b0);
    chk("slt_0", 32'(aOut), 32'd0);
    push(16'hFFFF); push(16'd1); step(OP_REP2, 4'd9, 16'd0, 1'b0);
    chk("slt_signed", 32'(aOut), 32'd1);

    push(16'd7); push(16'd3); step(OP_SWAP, 4'd0, 16'd0, 1'b0);
    chk("swap_a", 32'(aOut), 32'd7);
    chk("swap_b", 32'(bOut), 32'd3);
    push(16'd3); push(16'd7); step(OP_SWAP, 4'd0, 16'd0, 1'b0);
    chk("swap2_a", 32'(aOut), 32'd3);
    chk("swap2_b", 32'(bOut), 32'd7);

    push(16'h7FFF); push(16'd1); step(OP_REP2, 4'd0, 16'd0, 1'b0);
    chk("ovf_add_flag", 32'(last_ovf), 32'd1);
    chk("ovf_add_a", 32'(aOut), 32'h00008000);
    push(16'h8000); push(16'd1); step(OP_REP2, 4'd1, 16'd0, 1'b0);
    chk("ovf_sub_flag", 32'(last_ovf), 32'd1);
    chk("ovf_sub_a", 32'(aOut), 32'h00007FFF);
    push(16'd5); push(16'd6); step(OP_TEST, 4'd0, 16'd0, 1'b0);
    chk("no_ovf_flag", 32'(last_ovf), 32'd0);

    // Fill past capacity, then drain past empty.
    do_reset();
    for (int i = 0; i <= D; i++) push(16'(i + 100));
    chk("overpush_a", 32'(aOut), 32'(D + 100));
`ifdef STACK_STATUS_EN
    chk("full_after_overpush", 32'(full), 32'd1);
`endif
    for (int i = 0; i < D; i++) step(OP_DROP, 4'd0, 16'd0, 1'b0);
`ifdef STACK_STATUS_EN
    chk("empty_after_drain", 32'(empty), 32'd1);
`endif
    chk("drained_a", 32'(aOut), 32'd0);

    // Randomized operations with push-biased op mix.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] rop;
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        rop = ($urandom_range(0, 2) == 0) ? OP_PUSH : 3'($urandom_range(0, 7));
        step(rop, 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
